// File: rtl/fp_round_pack.sv
// rtl/fp_round_pack.sv - round-half-up, renormalise and pack {S,E,F} into a 2-entry output queue
module fp_round_pack #(
  parameter int SAT_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sign,
  input  logic [2:0]           exponent,
  input  logic [3:0]           significand,
  input  logic                 round_bit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           fp_out,
  output logic                 fp_sat,
  output logic [SAT_CNT_W-1:0] sat_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       rd_ptr, wr_ptr, rd_next;
  logic [8:0] mem [2];
  logic [8:0] head_q, head_d;
  logic [8:0] new_entry;
  logic [3:0] f_rnd;
  logic [2:0] e_rnd;
  logic       sat_rnd;
  logic       push, pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Carry out of an all-ones significand renormalises to 1.000 with exponent+1,
  // unless the exponent is already at its ceiling, where we clamp instead.
  always_comb begin
    f_rnd   = significand;
    e_rnd   = exponent;
    sat_rnd = 1'b0;
    if (round_bit) begin
      if (significand != 4'hf) begin
        f_rnd = significand + 4'd1;
      end else if (exponent != 3'd7) begin
        f_rnd = 4'h8;
        e_rnd = exponent + 3'd1;
      end else begin
        sat_rnd = 1'b1;
      end
    end
  end

  assign new_entry = {sat_rnd, sign, e_rnd, f_rnd};

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE:     if (push && !pop) state_d = FULL;
               else if (pop && !push) state_d = EMPTY;
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
  end

  // Head is registered so it can hold its last value once the queue drains.
  assign rd_next = rd_ptr ^ pop;
  always_comb begin
    head_d = (push && (wr_ptr == rd_next)) ? new_entry : mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      mem[0]    <= 9'd0;
      mem[1]    <= 9'd0;
      head_q    <= 9'd0;
      sat_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (state_d != EMPTY) head_q <= head_d;
      if (push && sat_rnd && (sat_count != {SAT_CNT_W{1'b1}}))
        sat_count <= sat_count + SAT_CNT_W'(1);
    end
  end

  assign fp_out = head_q[7:0];
  assign fp_sat = head_q[8];

endmodule

// File: tb/tb_fp_round_pack.sv
// tb/tb_fp_round_pack.sv - randomized bench with a queue-based reference model for fp_round_pack
module tb_fp_round_pack;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, sign, round_bit, out_ready;
  logic [2:0] exponent;
  logic [3:0] significand;
  logic       in_ready, out_valid, fp_sat;
  logic [7:0] fp_out;
  logic [7:0] sat_count;
  logic       in_ready2, out_valid2, fp_sat2;
  logic [7:0] fp_out2;
  logic [1:0] sat_count2;

  int checks = 0;
  int failures = 0;

  logic [8:0] model_q[$];
  int         model_sat;

  always #5 clk = ~clk;

  fp_round_pack #(.SAT_CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign(sign), .exponent(exponent), .significand(significand), .round_bit(round_bit),
    .out_valid(out_valid), .out_ready(out_ready), .fp_out(fp_out), .fp_sat(fp_sat),
    .sat_count(sat_count)
  );

  fp_round_pack #(.SAT_CNT_W(2)) u_dut_narrow (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .sign(sign), .exponent(exponent), .significand(significand), .round_bit(round_bit),
    .out_valid(out_valid2), .out_ready(out_ready), .fp_out(fp_out2), .fp_sat(fp_sat2),
    .sat_count(sat_count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference rounding: add the round bit to the significand as an integer; a
  // result of 16 overflows the 4-bit field.
  function automatic logic [8:0] ref_round(input logic s, input int e, input int f, input int rb);
    int m;
    m = f + rb;
    if (m < 16)     return {1'b0, s, 3'(e), 4'(m)};
    else if (e < 7) return {1'b0, s, 3'(e + 1), 4'd8};
    else            return {1'b1, s, 3'd7, 4'd15};
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Called just after a falling edge: drive inputs, check registered outputs,
  // cross the rising edge and advance the model.
  task automatic step(input logic iv, input logic s, input logic [2:0] e,
                      input logic [3:0] f, input logic rb, input logic ordy,
                      output logic accepted);
    logic       m_push, m_pop;
    logic [8:0] ent;
    in_valid = iv; sign = s; exponent = e; significand = f; round_bit = rb; out_ready = ordy;
    #1;
    check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    check("in_ready", 32'(in_ready), 32'(model_q.size() != 2));
    check("sat_count", 32'(sat_count), 32'(min_int(model_sat, 255)));
    check("sat_count_w2", 32'(sat_count2), 32'(min_int(model_sat, 3)));
    if (model_q.size() != 0) begin
      check("fp_out", 32'(fp_out), 32'(model_q[0][7:0]));
      check("fp_sat", 32'(fp_sat), 32'(model_q[0][8]));
    end
    m_push = iv && (model_q.size() != 2);
    m_pop  = ordy && (model_q.size() != 0);
    ent    = ref_round(s, int'(e), int'(f), int'(rb));
    @(posedge clk);
    if (m_pop) void'(model_q.pop_front());
    if (m_push) begin
      model_q.push_back(ent);
      if (ent[8]) model_sat++;
    end
    accepted = m_push;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b1; sign = 1'b1; exponent = 3'd7; significand = 4'hf; round_bit = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    model_q.delete();
    model_sat = 0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sat_count", 32'(sat_count), 32'd0);
    check("rst_fp_out", 32'(fp_out), 32'h00);
    check("rst_fp_sat", 32'(fp_sat), 32'd0);
  endtask

  logic acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; sign = 1'b0; exponent = 3'd0; significand = 4'd0;
    round_bit = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // single push, then observe and pop
    step(1'b1, 1'b0, 3'd3, 4'b1011, 1'b1, 1'b1, acc);
    check("tp1_fp_out", 32'(fp_out), 32'b0_011_1100);
    step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, acc);
    step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, acc);

    // renormalising carry and plain pass-through
    step(1'b1, 1'b1, 3'd2, 4'b1111, 1'b1, 1'b1, acc);
    check("tp2_carry", 32'(fp_out), 32'b1_011_1000);
    step(1'b1, 1'b0, 3'd5, 4'b1010, 1'b0, 1'b1, acc);
    check("tp2_plain", 32'(fp_out), 32'b0_101_1010);
    step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, acc);

    // saturation events: four clamps, narrow counter must stick at 3
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 3'd7, 4'b1111, 1'b1, 1'b1, acc);
      check("tp3_sat_out", 32'({fp_sat, fp_out}), 32'h17f);
    end
    step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, acc);
    check("tp3_sat_count", 32'(sat_count), 32'd4);
    check("tp3_sat_count_w2", 32'(sat_count2), 32'd3);

    // back-pressure: A, B fill the queue, C waits until accepted
    step(1'b1, 1'b0, 3'd1, 4'd1, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 3'd2, 4'd2, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 3'd3, 4'd3, 1'b0, 1'b0, acc);
    check("tp4_c_held", 32'(acc), 32'd0);
    step(1'b1, 1'b0, 3'd3, 4'd3, 1'b0, 1'b1, acc);
    check("tp4_full_pop_no_push", 32'(acc), 32'd0);
    for (int i = 0; i < 4 && !acc; i++) step(1'b1, 1'b0, 3'd3, 4'd3, 1'b0, 1'b1, acc);
    check("tp4_c_accepted", 32'(acc), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, acc);

    // fill, then reset with a pending input
    step(1'b1, 1'b1, 3'd4, 4'd6, 1'b1, 1'b0, acc);
    step(1'b1, 1'b0, 3'd6, 4'd9, 1'b0, 1'b0, acc);
    do_reset();
    step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, acc);

    // randomized traffic, biased toward the carry and clamp corners
    for (int i = 0; i < 400; i++) begin
      logic [2:0] e;
      logic [3:0] f;
      e = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom);
      f = ($urandom_range(0, 2) == 0) ? 4'hf : 4'($urandom);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), e, f, 1'($urandom),
           1'($urandom_range(0, 2) != 0), acc);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_round_pack.md
Name: fp_round_pack

Overview:
- Downstream stage of the linear-to-exponent converter in the floating-point conversion datapath.
- Accepts sign, 3-bit exponent, 4-bit significand and round bit per conversion, then applies round-half-up with significand renormalisation and exponent saturation.
- Packs the result into the 8-bit float {S, E[2:0], F[3:0]} and buffers it in a 2-entry output queue with valid/ready handshake.
- Keeps a saturating count of conversions that were clamped at the maximum magnitude.

Parameters:
- SAT_CNT_W, 8, width of the saturation-event counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents a conversion.
- in_ready  output  1  block can accept this cycle.
- sign  input  1  sign of the original 12-bit value.
- exponent  input  3  exponent from the upstream converter.
- significand  input  4  significand from the upstream converter.
- round_bit  input  1  first discarded bit below the significand.
- out_valid  output  1  head of the queue holds a result.
- out_ready  input  1  consumer accepts the head this cycle.
- fp_out  output  8  {S, E, F} at the head of the queue.
- fp_sat  output  1  head result was clamped.
- sat_count  output  SAT_CNT_W  number of clamped results accepted since reset; saturates at all-ones.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); it is sampled only on the rising edge of clk.
- Reset values:
  - queue count = 0, so out_valid = 0 and in_ready = 1.
  - fp_out = 8'h00, fp_sat = 0, sat_count = 0.
  - Both storage entries are cleared.
- Reset asserted mid-operation discards all queued results; an input presented in the reset cycle is not accepted.
- Push: occurs when in_valid && in_ready.
- Pop: occurs when out_valid && out_ready.
- in_ready = (count != 2). It depends only on the registered count, never combinationally on out_ready. A full queue therefore refuses a push even in a cycle where it pops.
- Rounding is combinational on the inputs and is written into the queue on push:
  - round_bit = 0: F = significand, E = exponent.
  - round_bit = 1 and significand != 4'b1111: F = significand + 1, E = exponent.
  - round_bit = 1, significand = 4'b1111, exponent < 7: F = 4'b1000, E = exponent + 1.
  - round_bit = 1, significand = 4'b1111, exponent = 7: F = 4'b1111, E = 3'b111, sat flag set.
  - S = sign, always passed unchanged.
- Latency: a result pushed at edge N into an empty queue drives out_valid = 1 and a valid fp_out from edge N onward. This gives 1-cycle latency.
- Ordering is strict FIFO. fp_out and fp_sat show the head entry and hold stable while out_valid && !out_ready.
- When count = 0, fp_out and fp_sat hold their last value. Consumers must not use them while out_valid = 0.
- Simultaneous push and pop:
  - count 1: count stays 1; the new entry becomes head after the pop.
  - count 0: only the push takes effect, since out_valid = 0.
- sat_count increments by 1 on each push whose sat flag is set. It holds at 2^SAT_CNT_W - 1 and does not wrap.
- Queue pointers wrap modulo 2. Count moves only through the values 0, 1 and 2.
- No internal state machine beyond count states EMPTY(0), ONE(1), FULL(2):
  - EMPTY -> ONE on push.
  - ONE -> FULL on push without pop.
  - ONE -> EMPTY on pop without push.
  - FULL -> ONE on pop.
  - Every other combination holds the current state.

Test Plan:
- Reset then a single push of sign=0, exp=3, sig=1011, rb=1 with out_ready=1 -> the following cycle shows out_valid=1, fp_out=8'b0_011_1100, fp_sat=0; out_valid drops after the pop.
- Push sign=1, exp=2, sig=1111, rb=1 -> fp_out=8'b1_011_1000 (renormalised carry), fp_sat=0; push exp=5, sig=1010, rb=0 -> fp_out=8'b0_101_1010.
- Push exp=7, sig=1111, rb=1 three times -> each result fp_out=8'b0_111_1111 with fp_sat=1, sat_count=3. With SAT_CNT_W=2, four such pushes -> sat_count holds at 3.
- Hold out_ready=0 and drive in_valid continuously with values A, B, C -> A and B are accepted, then in_ready=0 and C is held. Raise out_ready -> outputs are A then B then C in order, with no loss or duplication.
- At count=1, assert push and pop in the same cycle -> count stays 1, the old head is consumed, and the new value appears next. At count=2 with out_ready=1 and in_valid=1 -> no push that cycle, count becomes 1.
- Fill the queue to 2, assert rst for one cycle with in_valid=1 -> out_valid=0, in_ready=1, sat_count=0 and fp_out=8'h00 after the edge; no entry survives.
